addt_exp_arbiter: RTL and testbench

- Time-shares one registered P-bit exponent adder (Y = A + B) between N requesters in the fixed-to-floating-point conversion path, e.g. the sinh and cosh normalisation lanes of the expanded hyperbolic CORDIC.
- Uses round-robin arbitration and a per-requester valid/grant handshake.
- Output is one registered result slot with valid/ready backpressure, tagged with the requester index and a carry-out flag.

---
 rtl/addt_exp_arbiter.sv | 113 +++++++++++
 tb/tb_addt_exp_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/addt_exp_arbiter.sv
// addt_exp_arbiter: round-robin time-sharing of one registered P-bit exponent
// adder (Y = A + zext(B)) between N requesters. The result sits in one output
// slot with valid/ready backpressure. Each result carries the index of the
// requester that produced it and the carry out of the P-bit sum.
module addt_exp_arbiter #(
   parameter int P   = 8,
   parameter int W   = 8,
   parameter int N   = 2,
   parameter int IDW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   input  logic [N*P-1:0]   req_a,
   input  logic [N*W-1:0]   req_b,
   output logic [N-1:0]     grant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [P-1:0]     out_y,
   output logic             out_ovf,
   output logic [IDW-1:0]   out_id
);

   // (P+1)-bit sum of A and the zero-extended B. The top bit is the carry out.
   function automatic logic [P:0] exp_add(input logic [P-1:0] a, input logic [W-1:0] b);
      logic [P:0] a_ext;
      logic [P:0] b_ext;
      a_ext = {1'b0, a};
      b_ext = {{(P+1-W){1'b0}}, b};
      return a_ext + b_ext;
   endfunction

   logic             out_valid_r;
   logic [P-1:0]     out_y_r;
   logic             out_ovf_r;
   logic [IDW-1:0]   out_id_r;
   logic [IDW-1:0]   ptr_r;

   logic             can_accept_s;
   logic             sel_valid_s;
   logic [IDW-1:0]   sel_idx_s;
   logic [IDW-1:0]   ptr_next_s;
   logic [P-1:0]     sel_a_s;
   logic [W-1:0]     sel_b_s;
   logic [N-1:0]     grant_s;
   logic [P:0]       sum_s;

   // Round-robin search from ptr. The search is blocked during reset and while the slot cannot accept a result.
   always_comb begin
      int idx_v;
      can_accept_s = !out_valid_r || out_ready;
      grant_s      = {N{1'b0}};
      sel_valid_s  = 1'b0;
      sel_idx_s    = {IDW{1'b0}};
      ptr_next_s   = ptr_r;
      sel_a_s      = {P{1'b0}};
      sel_b_s      = {W{1'b0}};
      idx_v        = 0;
      if (!rst && can_accept_s) begin
         for (int k = 0; k < N; k++) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= N) begin
               idx_v = idx_v - N;
            end else begin
               idx_v = idx_v;
            end
            if (!sel_valid_s && req_valid[idx_v]) begin
               sel_valid_s      = 1'b1;
               grant_s[idx_v]   = 1'b1;
               sel_idx_s        = IDW'(idx_v);
               sel_a_s          = req_a[idx_v*P +: P];
               sel_b_s          = req_b[idx_v*W +: W];
               if (idx_v == N - 1) begin
                  ptr_next_s = {IDW{1'b0}};
               end else begin
                  ptr_next_s = IDW'(idx_v + 1);
               end
            end else begin
               sel_valid_s = sel_valid_s;
            end
         end
      end else begin
         sel_valid_s = 1'b0;
      end
      sum_s = exp_add(sel_a_s, sel_b_s);
   end

   // Result slot and pointer. A granted transfer loads the slot. A drain with no refill empties it. Otherwise everything holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_y_r     <= {P{1'b0}};
         out_ovf_r   <= 1'b0;
         out_id_r    <= {IDW{1'b0}};
         ptr_r       <= {IDW{1'b0}};
      end else if (sel_valid_s) begin
         out_valid_r <= 1'b1;
         out_y_r     <= sum_s[P-1:0];
         out_ovf_r   <= sum_s[P];
         out_id_r    <= sel_idx_s;
         ptr_r       <= ptr_next_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign grant     = grant_s;
   assign out_valid = out_valid_r;
   assign out_y     = out_y_r;
   assign out_ovf   = out_ovf_r;
   assign out_id    = out_id_r;

endmodule

// File: tb/tb_addt_exp_arbiter.sv
// Directed bench for addt_exp_arbiter. It drives inputs 1 ns after the rising
// edge and samples on the falling edge. Expected values are hand-computed.
module tb_addt_exp_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [1:0]  grant;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_y;
   logic        out_ovf;
   logic [0:0]  out_id;

   int n_pass  = 0;
   int n_total = 0;

   addt_exp_arbiter #(.P(8), .W(8), .N(2), .IDW(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_ovf   (out_ovf),
      .out_id    (out_id)
   );

   // free-running clock, 10 ns period
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] rr_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [7:0] rr_y     [4] = '{8'd2, 8'd20, 8'd2, 8'd20};
   logic [0:0] rr_id    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   // directed stimulus sequence
   initial begin
      // reset held for two cycles with both requests active
      rst = 1'b1; req_valid = 2'b11; out_ready = 1'b1;
      req_a = {8'd3, 8'd4}; req_b = {8'd5, 8'd6};
      @(negedge clk); chk("rst_grant_c1", grant, 2'b00);
      next_cycle();
      @(negedge clk); chk("rst_grant_c2", grant, 2'b00);
      next_cycle();
      rst = 1'b0; req_valid = 2'b00;
      @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_y", out_y, 8'd0);
      chk("rst_ovf", out_ovf, 1'b0);
      chk("rst_id", out_id, 1'b0);
      chk("idle_grant", grant, 2'b00);

      // single request from requester 1
      next_cycle();
      req_valid = 2'b10; req_a[15:8] = 8'd100; req_b[15:8] = 8'd27;
      @(negedge clk); chk("single_grant", grant, 2'b10);
      next_cycle();
      req_valid = 2'b00;
      @(negedge clk);
      chk("single_valid", out_valid, 1'b1);
      chk("single_y", out_y, 8'd127);
      chk("single_ovf", out_ovf, 1'b0);
      chk("single_id", out_id, 1'b1);

      // overflow from requester 0: 200 + 100 = 300 -> 44 with carry
      next_cycle();
      req_valid = 2'b01; req_a[7:0] = 8'd200; req_b[7:0] = 8'd100;
      @(negedge clk); chk("ovf_grant", grant, 2'b01);
      next_cycle();
      req_valid = 2'b00;
      @(negedge clk);
      chk("ovf_y", out_y, 8'd44);
      chk("ovf_flag", out_ovf, 1'b1);
      chk("ovf_id", out_id, 1'b0);

      // round-robin from a fresh reset (ptr = 0)
      next_cycle(); rst = 1'b1;
      next_cycle(); rst = 1'b0;
      @(negedge clk); chk("rr_pre_valid", out_valid, 1'b0);
      next_cycle();
      req_a = {8'd10, 8'd1}; req_b = {8'd10, 8'd1}; req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("rr_grant%0d", k), grant, rr_grant[k]);
         if (k > 0) begin
            chk($sformatf("rr_y%0d", k - 1), out_y, rr_y[k-1]);
            chk($sformatf("rr_id%0d", k - 1), out_id, rr_id[k-1]);
         end
         next_cycle();
      end
      req_valid = 2'b00;
      @(negedge clk);
      chk("rr_y3", out_y, rr_y[3]);
      chk("rr_id3", out_id, rr_id[3]);
      chk("rr_valid3", out_valid, 1'b1);

      // drain with no refill: valid drops, data holds
      next_cycle();
      @(negedge clk);
      chk("drain_valid", out_valid, 1'b0);
      chk("drain_y_hold", out_y, 8'd20);
      chk("drain_id_hold", out_id, 1'b1);

      // backpressure: result 127 held while out_ready is low
      next_cycle();
      req_valid = 2'b10; req_a[15:8] = 8'd100; req_b[15:8] = 8'd27;
      @(negedge clk); chk("bp_load_grant", grant, 2'b10);
      next_cycle();
      req_valid = 2'b01; req_a[7:0] = 8'd5; req_b[7:0] = 8'd6; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_grant%0d", k), grant, 2'b00);
         chk($sformatf("bp_y%0d", k), out_y, 8'd127);
         chk($sformatf("bp_valid%0d", k), out_valid, 1'b1);
         next_cycle();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", grant, 2'b01);
      chk("bp_release_y_old", out_y, 8'd127);
      next_cycle();
      req_valid = 2'b00; out_ready = 1'b0;
      @(negedge clk);
      chk("bp_refill_y", out_y, 8'd11);
      chk("bp_refill_valid", out_valid, 1'b1);
      chk("bp_refill_id", out_id, 1'b0);

      // reset while a result is pending under backpressure (ptr was 1)
      next_cycle(); rst = 1'b1;
      @(negedge clk); chk("mid_rst_grant", grant, 2'b00);
      next_cycle(); rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_y", out_y, 8'd0);
      next_cycle();
      req_valid = 2'b11; out_ready = 1'b1;
      @(negedge clk); chk("mid_rst_grant_ptr0", grant, 2'b01);
      next_cycle();
      req_valid = 2'b00;
      @(negedge clk);
      chk("mid_rst_y_new", out_y, 8'd11);
      chk("mid_rst_id_new", out_id, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
